// File: rtl/demux4_stream.sv
// rtl/demux4_stream.sv - 1-to-4 stream demultiplexer with registered, handshaked output channels
module demux4_stream #(
  parameter int N  = 7,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N:0]    entrada,
  input  logic [1:0]    selector,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          rs,
  input  logic          set,
  output logic [N:0]    salida_a,
  output logic [N:0]    salida_b,
  output logic [N:0]    salida_c,
  output logic [N:0]    salida_d,
  output logic          valid_a,
  output logic          valid_b,
  output logic          valid_c,
  output logic          valid_d,
  input  logic          ready_a,
  input  logic          ready_b,
  input  logic          ready_c,
  input  logic          ready_d,
  output logic [CW-1:0] cuenta
);

  logic [N:0] data_q [4];
  logic [3:0] vld_q;
  logic [3:0] rdy;
  logic       acc;
  logic [N:0] word;

  assign rdy = {ready_d, ready_c, ready_b, ready_a};

  // Only the addressed channel can stall the producer; a draining channel accepts (pass-through).
  assign in_ready = rst_n & ~rs & (~vld_q[selector] | rdy[selector]);
  assign acc      = in_valid & in_ready;
  assign word     = set ? {(N+1){1'b1}} : entrada;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) data_q[i] <= '0;
      vld_q  <= '0;
      cuenta <= '0;
    end else if (rs) begin
      for (int i = 0; i < 4; i++) data_q[i] <= '0;
      vld_q <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (acc && (selector == 2'(i))) begin
          data_q[i] <= word;
          vld_q[i]  <= 1'b1;
        end else if (vld_q[i] && rdy[i]) begin
          vld_q[i]  <= 1'b0;
        end
      end
      if (acc) cuenta <= cuenta + CW'(1);
    end
  end

  assign salida_a = data_q[0];
  assign salida_b = data_q[1];
  assign salida_c = data_q[2];
  assign salida_d = data_q[3];
  assign valid_a  = vld_q[0];
  assign valid_b  = vld_q[1];
  assign valid_c  = vld_q[2];
  assign valid_d  = vld_q[3];

endmodule

// File: tb/tb_demux4_stream.sv
// tb/tb_demux4_stream.sv - directed and random checks of demux4_stream against a channel-level model
module tb_demux4_stream;

  localparam int N  = 7;
  localparam int CW = 4;

  logic          clk;
  logic          rst_n;
  logic [N:0]    entrada;
  logic [1:0]    selector;
  logic          in_valid;
  logic          in_ready;
  logic          rs;
  logic          set;
  logic [N:0]    salida_a, salida_b, salida_c, salida_d;
  logic          valid_a, valid_b, valid_c, valid_d;
  logic          ready_a, ready_b, ready_c, ready_d;
  logic [CW-1:0] cuenta;

  demux4_stream #(.N(N), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .entrada(entrada), .selector(selector),
    .in_valid(in_valid), .in_ready(in_ready), .rs(rs), .set(set),
    .salida_a(salida_a), .salida_b(salida_b), .salida_c(salida_c), .salida_d(salida_d),
    .valid_a(valid_a), .valid_b(valid_b), .valid_c(valid_c), .valid_d(valid_d),
    .ready_a(ready_a), .ready_b(ready_b), .ready_c(ready_c), .ready_d(ready_d),
    .cuenta(cuenta)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // Reference: each channel is a one-word slot; the counter counts accepted words modulo 2^CW.
  logic       mv [4];
  logic [7:0] md [4];
  int         cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      mv[i] = 1'b0;
      md[i] = 8'h00;
    end
  endtask

  task automatic check_outputs();
    chk("valid_a", valid_a, mv[0]);
    chk("valid_b", valid_b, mv[1]);
    chk("valid_c", valid_c, mv[2]);
    chk("valid_d", valid_d, mv[3]);
    chk("salida_a", salida_a, md[0]);
    chk("salida_b", salida_b, md[1]);
    chk("salida_c", salida_c, md[2]);
    chk("salida_d", salida_d, md[3]);
    chk("cuenta", cuenta, cnt);
  endtask

  task automatic step(input logic v, input logic [1:0] s, input logic [7:0] d,
                      input logic st, input logic r, input logic [3:0] rd);
    logic exp_rdy;
    logic accepted;
    @(negedge clk);
    in_valid = v; selector = s; entrada = d; set = st; rs = r;
    {ready_d, ready_c, ready_b, ready_a} = rd;
    #1;
    exp_rdy = !r && (!mv[s] || rd[s]);
    chk("in_ready", in_ready, exp_rdy);
    accepted = v && exp_rdy;
    @(posedge clk);
    if (r) begin
      model_clear();
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (accepted && s == 2'(i)) begin
          mv[i] = 1'b1;
          md[i] = st ? 8'hFF : d;
        end else if (mv[i] && rd[i]) begin
          mv[i] = 1'b0;
        end
      end
      if (accepted) cnt = (cnt + 1) % (1 << CW);
    end
    #1;
    check_outputs();
  endtask

  initial begin
    rst_n = 1'b0; entrada = '0; selector = '0; in_valid = 1'b0; rs = 1'b0; set = 1'b0;
    ready_a = 1'b0; ready_b = 1'b0; ready_c = 1'b0; ready_d = 1'b0;
    model_clear();
    cnt = 0;
    #12;
    check_outputs();
    chk("in_ready_reset", in_ready, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("in_ready_release", in_ready, 1'b1);

    // routing
    step(1, 2'b00, 8'h11, 0, 0, 4'b0000);
    step(1, 2'b01, 8'h22, 0, 0, 4'b0000);
    step(1, 2'b10, 8'h33, 0, 0, 4'b0000);
    step(1, 2'b11, 8'h44, 0, 0, 4'b0000);
    chk("route_a", salida_a, 8'h11);
    chk("route_b", salida_b, 8'h22);
    chk("route_c", salida_c, 8'h33);
    chk("route_d", salida_d, 8'h44);
    chk("route_cnt", cuenta, 4);

    // backpressure on b; a drained first so it can take 8'h66
    step(1, 2'b01, 8'h55, 0, 0, 4'b0000);
    chk("bp_cnt", cuenta, 4);
    step(0, 2'b00, 8'h00, 0, 0, 4'b0001);
    step(1, 2'b00, 8'h66, 0, 0, 4'b0000);
    chk("bp_a", salida_a, 8'h66);
    step(1, 2'b01, 8'h55, 0, 0, 4'b0010);
    chk("bp_b", salida_b, 8'h55);
    chk("bp_valid_b", valid_b, 1'b1);

    // streaming into a continuously ready consumer
    for (int i = 1; i <= 8; i++) begin
      step(1, 2'b10, 8'(i), 0, 0, 4'b0100);
      chk("stream_c", salida_c, i);
    end

    // set and rs priority
    step(1, 2'b11, 8'h5A, 1, 0, 4'b1000);
    chk("set_d", salida_d, 8'hFF);
    step(1, 2'b11, 8'h5A, 1, 1, 4'b0000);
    chk("rs_valid_d", valid_d, 1'b0);
    chk("rs_salida_d", salida_d, 8'h00);

    // wrap: 17 accepts from a freshly reset counter
    @(negedge clk);
    rst_n = 1'b0;
    model_clear();
    cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 17; i++) step(1, 2'b10, 8'(i), 0, 0, 4'b0100);
    chk("wrap_cnt", cuenta, 1);

    // random traffic
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 3) != 0), 2'($urandom), 8'($urandom),
           1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 15) == 0), 4'($urandom));
    end

    // asynchronous reset between edges
    step(1, 2'b00, 8'hA5, 0, 0, 4'b0000);
    step(1, 2'b11, 8'h3C, 0, 0, 4'b0000);
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    model_clear();
    cnt = 0;
    check_outputs();
    chk("in_ready_async", in_ready, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 2'b01, 8'h77, 0, 0, 4'b0000);
    chk("post_reset_b", salida_b, 8'h77);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
